mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). One transaction is outstanding at a time. Data accesses have priority, and a streak limit guarantees fetch progress. IF responses can be killed by a pipeline flush. Sits between the IF/MEM stage logic and the memory macro; `if_gnt`/`d_gnt` low is the stage stall source.

## Interface

Parameters:
- `MEM_LAT`, default 2: cycles from the `mem_en` cycle to the cycle `mem_rdata` is valid; legal range 1..15.
- `STREAK_MAX`, default 4: maximum consecutive data grants while `if_req` is waiting; legal range 1..15.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `if_req`, in, 1: fetch request; held until `if_gnt`.
- `if_addr`, in, 32: fetch address.
- `if_flush`, in, 1: kill the pending or outstanding fetch.
- `if_gnt`, out, 1: fetch accepted this cycle (combinational).
- `if_rvalid`, out, 1: fetch data valid (one-cycle pulse).
- `if_rdata`, out, 32: fetch data.
- `d_req`, in, 1: data request; held until `d_gnt`.
- `d_we`, in, 1: 1 = store, 0 = load.
- `d_addr`, in, 32: data address.
- `d_wdata`, in, 32: store data.
- `d_gnt`, out, 1: data request accepted this cycle (combinational).
- `d_done`, out, 1: load data valid / store complete (one-cycle pulse).
- `d_rdata`, out, 32: load data; 0 on store completion.
- `mem_en`, out, 1: memory access strobe.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, 32: memory address.
- `mem_wdata`, out, 32: memory write data.
- `mem_rdata`, in, 32: memory read data.
- `busy`, out, 1: high while a transaction is outstanding (ISSUE/WAIT).

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- Arbitration occurs only in IDLE and RESP. RESP behaves as IDLE for accepting requests.
- Winner rule:
  - `d_req` wins unless `if_req` is high, `if_flush` is low and `streak == STREAK_MAX`; in that case IF wins.
  - IF is eligible only when `if_flush` is low.
- On grant:
  - Latch owner, we, addr, wdata. IF grants force we = 0.
  - Assert the matching gnt for that cycle only.
  - Next state is ISSUE.
- No eligible request in IDLE/RESP: next state is IDLE.
- ISSUE:
  - `mem_en` = 1; `mem_we`/`mem_addr`/`mem_wdata` come from the latched request.
  - A 4-bit latency counter loads `MEM_LAT`; next state is WAIT.
  - `mem_addr` and `mem_wdata` hold their latched values in all states; `mem_en` and `mem_we` are 0 outside ISSUE.
- WAIT:
  - The counter decrements each cycle.
  - When it reaches 1, `mem_rdata` is captured into the owner's rdata register (d_rdata gets 0 for stores); next state is RESP.
- RESP:
  - Owner's `if_rvalid`/`d_done` = 1 for exactly this cycle.
  - `if_rdata`/`d_rdata` hold their last captured value until the next capture for that owner.
- Streak counter, 4 bits:
  - Data grant while `if_req` is high: increment, saturating at `STREAK_MAX`.
  - Data grant while `if_req` is low: reset to 0.
  - IF grant: reset to 0.
- Flush:
  - `if_flush` high in any cycle between an IF grant and its RESP cycle inclusive sets a kill flag. The memory access still completes and timing is unchanged, but `if_rvalid` is suppressed and `if_rdata` is not updated.
  - The kill flag clears on leaving RESP.
- Reset:
  - All outputs 0, state IDLE, streak 0, kill flag 0, rdata registers 0.
  - An in-flight response is discarded: no rvalid/done after reset, even if `mem_rdata` arrives.

## Timing

- With `MEM_LAT` = 2, request accepted in cycle t:
  - t: gnt
  - t+1: mem_en
  - t+3: capture
  - t+4: rvalid/done, and earliest next gnt
- Throughput: one transaction per `MEM_LAT`+2 cycles under continuous requests.
- Simultaneous `if_req` and `d_req` with streak below max: data granted, IF waits. After `STREAK_MAX` data grants IF is granted, then data resumes.
- gnt is never asserted in ISSUE or WAIT. Requests held through those states are re-arbitrated in RESP.
- `rst` asserted in the same cycle as a grant: reset wins, no gnt.

## Structure

- Shared package gets:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP}
  - `arb_owner_t` enum {OWN_IF, OWN_D}
  - `mem_req_t` packed struct {we, addr[31:0], wdata[31:0]}
- Sub-module `arb_priority`: combinational winner select from `if_req`, `if_flush`, `d_req`, streak and `STREAK_MAX`. FSM, counters and registers stay in the top module.

## Test plan

- Reset then single load, `d_addr`=0x40, `mem_rdata`=0xDEADBEEF → d_gnt at t, mem_en at t+1, d_done with d_rdata=0xDEADBEEF at t+4.
- Single store, `d_addr`=0x80, `d_wdata`=0x12345678 → mem_en=1, mem_we=1, mem_addr=0x80, mem_wdata=0x12345678 at t+1; d_done at t+4 with d_rdata=0.
- `if_req` and `d_req` held high continuously, `STREAK_MAX`=4 → grant order D,D,D,D,I,D,D,D,D,I; grants spaced 4 cycles apart.
- IF granted, `if_flush` pulsed at t+2 → mem_en at t+1 still occurs, no if_rvalid at t+4, if_rdata unchanged, next grant possible at t+4.
- `rst` asserted at t+2 of a load → all outputs 0 next cycle, no d_done ever, state IDLE, fresh request granted normally.
- `MEM_LAT`=1, back-to-back IF fetches 0x0, 0x4 → if_rvalid at t+3 and t+6 with the matching data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified I/D memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Stage-side and memory-side signals of the arbiter; slave = arbiter, master = stages/memory.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_arb_priority.sv
// Winner select: data first, unless a waiting fetch has been starved for STREAK_MAX data grants.
module arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic             if_req,
  input  logic             if_flush,
  input  logic             d_req,
  input  logic [CNT_W-1:0] streak,
  output logic             grant_if_c,
  output logic             grant_d_c
);

  logic if_elig_c;
  logic if_forced_c;

  always_comb begin
    if_elig_c   = if_req & ~if_flush;
    if_forced_c = if_elig_c & (streak == CNT_W'(STREAK_MAX));
    grant_d_c   = d_req & ~if_forced_c;
    grant_if_c  = if_elig_c & ~grant_d_c;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one access outstanding.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STREAK_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  mem_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  streak_q, streak_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              d_done_q, d_done_d;
  logic              if_resp_q, if_resp_d;

  logic grant_if_c, grant_d_c;
  logic arb_ok_c, kill_now_c;
  logic if_gnt_c, d_gnt_c;

  arb_priority #(.STREAK_MAX(STREAK_MAX)) u_prio (
    .if_req     (bus.if_req),
    .if_flush   (bus.if_flush),
    .d_req      (bus.d_req),
    .streak     (streak_q),
    .grant_if_c (grant_if_c),
    .grant_d_c  (grant_d_c)
  );

  // Next-state, capture and output-register computation.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    kill_d     = kill_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt_c   = 1'b0;
    d_gnt_c    = 1'b0;
    arb_ok_c   = ((state_q == IDLE) || (state_q == RESP)) && !rst;
    kill_now_c = kill_q | ((owner_q == OWN_IF) & bus.if_flush);

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        kill_d  = 1'b0;
        if (arb_ok_c && grant_d_c) begin
          d_gnt_c  = 1'b1;
          owner_d  = OWN_D;
          req_d    = mem_req_t'{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
          streak_d = bus.if_req ? ((streak_q < CNT_W'(STREAK_MAX)) ? streak_q + CNT_W'(1) : streak_q)
                                : '0;
          state_d  = ISSUE;
        end else if (arb_ok_c && grant_if_c) begin
          if_gnt_c = 1'b1;
          owner_d  = OWN_IF;
          req_d    = mem_req_t'{we: 1'b0, addr: bus.if_addr, wdata: '0};
          streak_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        kill_d  = kill_now_c;
        state_d = WAIT;
      end
      WAIT: begin
        kill_d = kill_now_c;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d = req_q.we ? '0 : bus.mem_rdata;
          end else if (!kill_now_c) begin
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    mem_en_d  = (state_d == ISSUE);
    mem_we_d  = (state_d == ISSUE) & req_d.we;
    busy_d    = (state_d == ISSUE) || (state_d == WAIT);
    d_done_d  = (state_d == RESP) && (owner_d == OWN_D);
    if_resp_d = (state_d == RESP) && (owner_d == OWN_IF) && !kill_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      req_q      <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      kill_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      d_done_q   <= 1'b0;
      if_resp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      kill_q     <= kill_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      d_done_q   <= d_done_d;
      if_resp_q  <= if_resp_d;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  // A flush in the response cycle itself still suppresses the fetch response.
  assign bus.if_rvalid = if_resp_q & ~bus.if_flush;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.busy      = busy_q;

endmodule
